// File: rtl/cp0_regfile_ext.sv
// CP0 register file beside WB: Status, Cause, EPC, BadVAddr, Count, Compare,
// external interrupt synchronisation, Count-based timer interrupt and a registered interrupt request.

module cp0_int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

module cp0_regfile_ext #(
  parameter int EXT_INT_W   = 6,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 2,
  parameter int TIMER_LINE  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [EXT_INT_W-1:0] ext_int,
  input  logic                 mtc0_we,
  input  logic [7:0]           c0_addr,
  input  logic [31:0]          c0_wdata,
  input  logic                 wb_ex,
  input  logic                 wb_bd,
  input  logic [4:0]           wb_excode,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic                 eret_flush,
  output logic [31:0]          c0_rdata,
  output logic [31:0]          c0_epc,
  output logic                 has_int,
  output logic                 timer_int
);
  localparam logic [4:0] R_BADV = 5'd8,  R_COUNT = 5'd9,  R_CMP = 5'd11,
                         R_STAT = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;
  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(COUNT_DIV - 1);

  typedef struct packed {
    logic        ex;
    logic        bd;
    logic [4:0]  excode;
    logic [31:0] pc;
    logic [31:0] badvaddr;
  } wb_req_t;

  wb_req_t wb;
  assign wb = '{ex: wb_ex, bd: wb_bd, excode: wb_excode, pc: wb_pc, badvaddr: wb_badvaddr};

  logic [7:0]    status_im;
  logic          status_exl, status_ie;
  logic          cause_bd, cause_ti;
  logic [5:0]    cause_ip_hw;
  logic [1:0]    cause_ip_sw;
  logic [4:0]    cause_exc;
  logic [31:0]   epc, badvaddr, count, compare;
  logic [DW-1:0] div;

  // Write decode; exception and ERET commits squash any same-cycle MTC0.
  logic [4:0] reg_idx;
  logic       sel_ok, wr;
  logic       wr_status, wr_cause, wr_epc, wr_badv, wr_count, wr_cmp;

  assign reg_idx   = c0_addr[7:3];
  assign sel_ok    = (c0_addr[2:0] == 3'd0);
  assign wr        = mtc0_we & sel_ok & ~wb.ex & ~eret_flush;
  assign wr_status = wr & (reg_idx == R_STAT);
  assign wr_cause  = wr & (reg_idx == R_CAUSE);
  assign wr_epc    = wr & (reg_idx == R_EPC);
  assign wr_badv   = wr & (reg_idx == R_BADV);
  assign wr_count  = wr & (reg_idx == R_COUNT);
  assign wr_cmp    = wr & (reg_idx == R_CMP);

  logic [EXT_INT_W-1:0] ext_sync;
  logic [5:0]           ip_hw_nxt;

  for (genvar i = 0; i < EXT_INT_W; i++) begin : g_sync
    cp0_int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ext_int[i]),
      .q     (ext_sync[i])
    );
  end

  // IP[2+k]: synchronised line k (if present) OR'd with TI on the timer line.
  for (genvar k = 0; k < 6; k++) begin : g_ip
    logic ext_bit, ti_bit;
    if (k < EXT_INT_W) begin : g_ext
      assign ext_bit = ext_sync[k];
    end else begin : g_noext
      assign ext_bit = 1'b0;
    end
    assign ti_bit       = (k + 2 == TIMER_LINE) ? cause_ti : 1'b0;
    assign ip_hw_nxt[k] = ext_bit | ti_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (wb.ex) begin
      status_exl <= 1'b1;
    end else if (eret_flush) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= c0_wdata[15:8];
      status_exl <= c0_wdata[1];
      status_ie  <= c0_wdata[0];
    end
  end

  // A nested exception (EXL already set) keeps the original BD/EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_bd  <= 1'b0;
      cause_exc <= '0;
      epc       <= '0;
    end else if (wb.ex) begin
      cause_exc <= wb.excode;
      if (!status_exl) begin
        cause_bd <= wb.bd;
        epc      <= wb.bd ? wb.pc - 32'd4 : wb.pc;
      end
    end else if (wr_epc) begin
      epc <= c0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr <= '0;
    end else if (wb.ex && (wb.excode == 5'd4 || wb.excode == 5'd5)) begin
      badvaddr <= wb.badvaddr;
    end else if (wr_badv) begin
      badvaddr <= c0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_ip_sw <= '0;
      cause_ip_hw <= '0;
    end else begin
      cause_ip_hw <= ip_hw_nxt;
      if (wr_cause) cause_ip_sw <= c0_wdata[9:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      div   <= '0;
    end else if (wr_count) begin
      count <= c0_wdata;
      div   <= '0;
    end else if (div == DIV_MAX) begin
      count <= count + 32'd1;
      div   <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // TI is sticky; a Compare write wins over a same-cycle match.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare  <= '0;
      cause_ti <= 1'b0;
    end else if (wr_cmp) begin
      compare  <= c0_wdata;
      cause_ti <= 1'b0;
    end else if (count == compare) begin
      cause_ti <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    has_int <= 1'b0;
    else if (wb.ex || eret_flush) has_int <= 1'b0;
    else has_int <= (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;
  end

  logic [31:0] status_r, cause_r;
  assign status_r = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_r  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b0};

  always_comb begin
    c0_rdata = '0;
    if (sel_ok) begin
      case (reg_idx)
        R_BADV:  c0_rdata = badvaddr;
        R_COUNT: c0_rdata = count;
        R_CMP:   c0_rdata = compare;
        R_STAT:  c0_rdata = status_r;
        R_CAUSE: c0_rdata = cause_r;
        R_EPC:   c0_rdata = epc;
        default: c0_rdata = '0;
      endcase
    end
  end

  assign c0_epc    = epc;
  assign timer_int = cause_ti;
endmodule

// File: tb/tb_cp0_regfile_ext.sv
// Directed bench for cp0_regfile_ext: table of MTC0/read-back vectors plus
// hand-written exception, timer, interrupt-latency and priority sequences.

module tb_cp0_regfile_ext;
  localparam int EXT_INT_W = 6;
  localparam int SYNC      = 2;

  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58,
                         A_STAT = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [EXT_INT_W-1:0] ext_int;
  logic                 mtc0_we;
  logic [7:0]           c0_addr;
  logic [31:0]          c0_wdata;
  logic                 wb_ex, wb_bd;
  logic [4:0]           wb_excode;
  logic [31:0]          wb_pc, wb_badvaddr;
  logic                 eret_flush;
  logic [31:0]          c0_rdata, c0_epc;
  logic                 has_int, timer_int;

  int total = 0;
  int bad   = 0;

  cp0_regfile_ext #(.EXT_INT_W(EXT_INT_W), .SYNC_STAGES(SYNC), .COUNT_DIV(2), .TIMER_LINE(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_int     (ext_int),
    .mtc0_we     (mtc0_we),
    .c0_addr     (c0_addr),
    .c0_wdata    (c0_wdata),
    .wb_ex       (wb_ex),
    .wb_bd       (wb_bd),
    .wb_excode   (wb_excode),
    .wb_pc       (wb_pc),
    .wb_badvaddr (wb_badvaddr),
    .eret_flush  (eret_flush),
    .c0_rdata    (c0_rdata),
    .c0_epc      (c0_epc),
    .has_int     (has_int),
    .timer_int   (timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    c0_addr = a;
    #1;
    d = c0_rdata;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    mtc0_we = 1'b1; c0_addr = a; c0_wdata = d;
    tick(1);
    mtc0_we = 1'b0;
  endtask

  task automatic wbex(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                      input logic [31:0] badv);
    @(negedge clk);
    wb_ex = 1'b1; wb_bd = bd; wb_pc = pc; wb_excode = code; wb_badvaddr = badv;
    tick(1);
    wb_ex = 1'b0;
  endtask

  task automatic eret();
    @(negedge clk);
    eret_flush = 1'b1;
    tick(1);
    eret_flush = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    vecs[0] = '{"status_all1",  1'b1, A_STAT,  32'hFFFF_FFFF, 32'h0040_FF03};
    vecs[1] = '{"status_zero",  1'b1, A_STAT,  32'h0000_0000, 32'h0040_0000};
    vecs[2] = '{"epc_wr",       1'b1, A_EPC,   32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{"compare_wr",   1'b1, A_CMP,   32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{"unused_reg10", 1'b1, 8'h50,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{"epc_sel1_rd",  1'b1, 8'h71,   32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6] = '{"epc_kept",     1'b0, A_EPC,   32'h0000_0000, 32'h1234_5678};
    vecs[7] = '{"reg0_rd",      1'b1, 8'h00,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{"cause_all1",   1'b1, A_CAUSE, 32'hFFFF_FFFF, 32'h0000_0300};
    vecs[9] = '{"cause_zero",   1'b1, A_CAUSE, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; ext_int = '0; mtc0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    wb_ex = 1'b0; wb_bd = 1'b0; wb_excode = '0; wb_pc = '0; wb_badvaddr = '0;
    eret_flush = 1'b0;
    tick(3);

    rd(A_STAT, r);  check("rst_status", r, 32'h0040_0000);
    rd(A_CAUSE, r); check("rst_cause", r, 32'h0);
    rd(A_COUNT, r); check("rst_count", r, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_timer_int", {31'b0, timer_int}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mtc0_we = vecs[i].we; c0_addr = vecs[i].addr; c0_wdata = vecs[i].wdata;
      tick(1);
      mtc0_we = 1'b0;
      #1;
      check(vecs[i].name, c0_rdata, vecs[i].exp);
    end

    // Exception in a delay slot, then nested exception, then ERET.
    wbex(1'b1, 32'hBFC0_0100, 5'd4, 32'h0000_1235);
    check("ex1_epc_port", c0_epc, 32'hBFC0_00FC);
    rd(A_EPC, r);   check("ex1_epc", r, 32'hBFC0_00FC);
    rd(A_CAUSE, r); check("ex1_cause", r, 32'h8000_0010);
    rd(A_BADV, r);  check("ex1_badv", r, 32'h0000_1235);
    rd(A_STAT, r);  check("ex1_status", r, 32'h0040_0002);
    wbex(1'b0, 32'h0000_0200, 5'd0, 32'hFFFF_0000);
    rd(A_EPC, r);   check("ex2_epc_kept", r, 32'hBFC0_00FC);
    rd(A_CAUSE, r); check("ex2_cause", r, 32'h8000_0000);
    rd(A_BADV, r);  check("ex2_badv_kept", r, 32'h0000_1235);
    eret();
    rd(A_STAT, r);  check("eret_status", r, 32'h0040_0000);

    // Count wrap with divide-by-2, then TI and IP[7].
    mtc0(A_CMP, 32'h0);
    mtc0(A_COUNT, 32'hFFFF_FFFE);
    tick(2);
    rd(A_COUNT, r); check("count_ff", r, 32'hFFFF_FFFF);
    tick(2);
    rd(A_COUNT, r); check("count_wrap", r, 32'h0);
    check("ti_before", {31'b0, timer_int}, 32'h0);
    tick(1);
    check("ti_set", {31'b0, timer_int}, 32'h1);
    tick(1);
    rd(A_CAUSE, r); check("cause_ip7", {31'b0, r[15]}, 32'h1);

    // Timer interrupt through IM[7]; exception and ERET force has_int low.
    mtc0(A_STAT, 32'h0000_8001);
    check("hi_same_cycle", {31'b0, has_int}, 32'h0);
    tick(1);
    check("hi_timer", {31'b0, has_int}, 32'h1);
    wbex(1'b0, 32'h0000_0400, 5'd0, 32'h0);
    check("hi_ex_drop", {31'b0, has_int}, 32'h0);
    rd(A_STAT, r);  check("ex3_status", r, 32'h0040_8003);
    rd(A_EPC, r);   check("ex3_epc", r, 32'h0000_0400);
    rd(A_BADV, r);  check("ex3_badv_kept", r, 32'h0000_1235);
    eret();
    check("hi_eret_drop", {31'b0, has_int}, 32'h0);
    tick(1);
    check("hi_after_eret", {31'b0, has_int}, 32'h1);

    mtc0(A_COUNT, 32'h0000_0100);
    mtc0(A_CMP, 32'h0000_0005);
    check("ti_clear", {31'b0, timer_int}, 32'h0);
    mtc0(A_CMP, 32'h8000_0000);

    // ext_int[0] latency to IP[2] and has_int.
    mtc0(A_STAT, 32'h0000_0401);
    tick(3);
    check("ext_idle_hi", {31'b0, has_int}, 32'h0);
    @(negedge clk);
    ext_int[0] = 1'b1;
    tick(SYNC);
    rd(A_CAUSE, r); check("ext_on_early", {31'b0, r[10]}, 32'h0);
    tick(1);
    rd(A_CAUSE, r); check("ext_on_ip", {31'b0, r[10]}, 32'h1);
    check("ext_on_hi_early", {31'b0, has_int}, 32'h0);
    tick(1);
    check("ext_on_hi", {31'b0, has_int}, 32'h1);
    @(negedge clk);
    ext_int[0] = 1'b0;
    tick(SYNC);
    rd(A_CAUSE, r); check("ext_off_early", {31'b0, r[10]}, 32'h1);
    tick(1);
    rd(A_CAUSE, r); check("ext_off_ip", {31'b0, r[10]}, 32'h0);
    check("ext_off_hi_early", {31'b0, has_int}, 32'h1);
    tick(1);
    check("ext_off_hi", {31'b0, has_int}, 32'h0);

    // Same-cycle priority: wb_ex beats MTC0, ERET beats MTC0.
    @(negedge clk);
    wb_ex = 1'b1; wb_bd = 1'b0; wb_pc = 32'h0000_0600; wb_excode = 5'd8; wb_badvaddr = 32'h0;
    mtc0_we = 1'b1; c0_addr = A_STAT; c0_wdata = 32'h0;
    tick(1);
    wb_ex = 1'b0; mtc0_we = 1'b0;
    rd(A_STAT, r);  check("prio_ex_status", r, 32'h0040_0403);
    rd(A_EPC, r);   check("prio_ex_epc", r, 32'h0000_0600);
    rd(A_CAUSE, r); check("prio_ex_cause", r, 32'h0000_0020);
    mtc0(A_CAUSE, 32'h0000_0300);
    rd(A_CAUSE, r); check("cause_sw_ip", r, 32'h0000_0320);
    @(negedge clk);
    eret_flush = 1'b1; mtc0_we = 1'b1; c0_addr = A_STAT; c0_wdata = 32'h0;
    tick(1);
    eret_flush = 1'b0; mtc0_we = 1'b0;
    rd(A_STAT, r);  check("prio_eret_status", r, 32'h0040_0401);
    mtc0(8'h61, 32'h0);
    rd(8'h61, r);   check("sel1_read", r, 32'h0);
    rd(A_STAT, r);  check("sel1_no_write", r, 32'h0040_0401);

    // Mid-operation reset.
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    rd(A_STAT, r);  check("rst2_status", r, 32'h0040_0000);
    rd(A_CAUSE, r); check("rst2_cause", r, 32'h0);
    rd(A_EPC, r);   check("rst2_epc", r, 32'h0);
    rd(A_BADV, r);  check("rst2_badv", r, 32'h0);
    rd(A_COUNT, r); check("rst2_count", r, 32'h0);
    check("rst2_has_int", {31'b0, has_int}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
